// File: rtl/add_multimot_seq_pkg.sv
// +----------------------------------------------------------------------+
// | add_multimot_seq_pkg                                                 |
// | Shared word width and controller state encoding for the multi-word   |
// | sequential adder.                                                    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package add_multimot_seq_pkg;

  localparam int LARGEUR_MOT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/add_multimot_seq_operation16.sv
// +----------------------------------------------------------------------+
// | operation16                                                          |
// | 16-bit adder slice: s = a + b + r0, r1 is the carry out.             |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module operation16
  import add_multimot_seq_pkg::*;
(
  input  logic [LARGEUR_MOT-1:0] a,
  input  logic [LARGEUR_MOT-1:0] b,
  input  logic                   r0,
  output logic [LARGEUR_MOT-1:0] s,
  output logic                   r1
);

  assign {r1, s} = {1'b0, a} + {1'b0, b} + {{LARGEUR_MOT{1'b0}}, r0};

endmodule

`default_nettype wire

// File: rtl/add_multimot_seq.sv
// +----------------------------------------------------------------------+
// | add_multimot_seq                                                     |
// | Multi-word adder: one 16-bit slice per clock through operation16,    |
// | LSW first, with ready/valid handshakes on both sides.                |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module add_multimot_seq
  import add_multimot_seq_pkg::*;
#(
  parameter int NB_MOTS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LARGEUR_MOT*NB_MOTS-1:0] a,
  input  logic [LARGEUR_MOT*NB_MOTS-1:0] b,
  input  logic                           cin,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LARGEUR_MOT*NB_MOTS-1:0] s,
  output logic                           cout,
  output logic                           ovf
);

  localparam int c_w     = LARGEUR_MOT * NB_MOTS;
  localparam int c_idx_w = (NB_MOTS > 1) ? $clog2(NB_MOTS) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NB_MOTS - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_w-1:0]       r_a;
  logic [c_w-1:0]       r_b;
  logic [c_w-1:0]       r_s;
  logic [c_idx_w-1:0]   r_idx;
  logic                 r_carry;
  logic                 r_cout;
  logic                 r_ovf;
  logic [LARGEUR_MOT-1:0] w_a_slice;
  logic [LARGEUR_MOT-1:0] w_b_slice;
  logic [LARGEUR_MOT-1:0] w_sum;
  logic                 w_r1;
  logic                 w_last;

  assign w_a_slice = r_a[r_idx*LARGEUR_MOT +: LARGEUR_MOT];
  assign w_b_slice = r_b[r_idx*LARGEUR_MOT +: LARGEUR_MOT];
  assign w_last    = (r_idx == c_last_idx);

  // r_carry holds cin for slice 0, then the carry of the previous slice
  operation16 u_operation16 (
    .a  (w_a_slice),
    .b  (w_b_slice),
    .r0 (r_carry),
    .s  (w_sum),
    .r1 (w_r1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = CALC;
      end
      CALC: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
          end
        end
        CALC: begin
          r_s[r_idx*LARGEUR_MOT +: LARGEUR_MOT] <= w_sum;
          r_carry <= w_r1;
          if (w_last) begin
            r_cout <= w_r1;
            // the MSW slice being written carries the sign of the result
            r_ovf  <= (r_a[c_w-1] == r_b[c_w-1]) && (w_sum[LARGEUR_MOT-1] != r_a[c_w-1]);
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign s    = r_s;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

`default_nettype wire
